fwd_scoreboard: RTL and testbench

- Parametrised forwarding and hazard unit for the pipelined MIPS core.
- Tracks every in-flight register writer in a shift-register scoreboard with DEPTH post-issue stages (default EX/MEM/WB).
- For each of NSRC source operands at the issue (ID) stage it selects the youngest ready producer, or raises a stall when that producer's result is not yet available (load-use, multi-cycle results).
- It replaces fixed two-stage compare logic: depth, port count and per-instruction result latency are all generic.

---
 rtl/fwd_pkg.sv | 26 ++
 rtl/fwd_pick.sv | 53 +++++
 rtl/fwd_scoreboard.sv | 123 ++++++++++++
 tb/tb_fwd_scoreboard.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// ---------------------------------------------------------------------------
// fwd_pkg
// Shared types and constants for the forwarding / hazard scoreboard.
//   sb_entry_t : one scoreboard slot {v, dst, lat}. Field widths are fixed
//                upper bounds so the type can live in a package; the
//                modules zero-extend their RW / LW wide values into it.
//   FWD_*      : forward-select encodings for the default 3-stage depth.
// ---------------------------------------------------------------------------
package fwd_pkg;

  // Upper bounds for register index and latency fields (RW, LW <= 8).
  localparam int SB_DST_W = 8;
  localparam int SB_LAT_W = 8;

  typedef struct packed {
    logic                v;
    logic [SB_DST_W-1:0] dst;
    logic [SB_LAT_W-1:0] lat;
  } sb_entry_t;

  localparam int FWD_RF  = 0;
  localparam int FWD_EX  = 1;
  localparam int FWD_MEM = 2;
  localparam int FWD_WB  = 3;

endpackage

// File: rtl/fwd_pick.sv
// ---------------------------------------------------------------------------
// fwd_pick
// Operand-level forwarding decision for one source register.
// Searches the scoreboard from stage 1 (youngest) upward; the first valid
// entry whose destination matches decides the outcome: forward from that
// stage if its result is ready, otherwise flag a hazard. Older matches are
// shadowed even when ready, because they hold a stale value.
// Ports:
//   i_src    [RW]    source register index
//   i_used           operand actually reads a register
//   i_valid          an instruction is present at issue
//   i_sb     [DEPTH] scoreboard entries, index k = pipeline stage k
//   o_sel    [SW]    0 = register file, k = forward from stage k
//   o_hazard         youngest producer not ready yet
// ---------------------------------------------------------------------------
import fwd_pkg::*;

module fwd_pick #(
  parameter int RW    = 5,
  parameter int DEPTH = 3,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  logic                  i_valid,
  input  logic                  i_used,
  input  logic [RW-1:0]         i_src,
  input  sb_entry_t [DEPTH:1]   i_sb,
  output logic [SW-1:0]         o_sel,
  output logic                  o_hazard
);

  logic w_req;
  logic w_found;

  always_comb begin
    o_sel    = SW'(FWD_RF);
    o_hazard = 1'b0;
    w_found  = 1'b0;
    // $0 is hard-wired zero and never needs forwarding.
    w_req    = i_valid && i_used && (i_src != '0);
    for (int k = 1; k <= DEPTH; k++) begin
      if (w_req && !w_found && i_sb[k].v && (i_sb[k].dst == SB_DST_W'(i_src))) begin
        w_found = 1'b1;
        // Result exists at the end of stage lat+1, so stage k holds it when k > lat.
        if (SB_LAT_W'(k) > i_sb[k].lat) begin
          o_sel = SW'(k);
        end else begin
          o_hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard
// Forwarding and hazard unit for the pipelined MIPS core. Every accepted
// register writer is shifted through DEPTH post-issue stages; each source
// operand at issue is resolved against it by a fwd_pick instance.
// DEPTH must be >= 2 so the latency field has at least one bit.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   id_valid             instruction present at issue
//   id_src [NSRC*RW]     source indices, operand i at [i*RW +: RW]
//   id_src_used [NSRC]   per-operand register-read flag
//   id_wr, id_dst [RW]   instruction writes register id_dst
//   id_lat [LW]          result ready at end of stage id_lat+1
//   flush                kill the instruction at issue
//   fwd_sel [NSRC*SW]    per-operand forward select (don't-care while stall)
//   stall                hold PC and IF/ID, bubble into EX
//   stall_cnt [32]       saturating stall-cycle counter, only when the
//                        FWD_STALL_CNT_EN macro is defined
// ---------------------------------------------------------------------------
import fwd_pkg::*;

module fwd_scoreboard #(
  parameter int RW    = 5,
  parameter int DEPTH = 3,
  parameter int NSRC  = 2,
  parameter int SW    = $clog2(DEPTH + 1),
  parameter int LW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [NSRC*RW-1:0] id_src,
  input  logic [NSRC-1:0]    id_src_used,
  input  logic               id_wr,
  input  logic [RW-1:0]      id_dst,
  input  logic [LW-1:0]      id_lat,
  input  logic               flush,
  output logic [NSRC*SW-1:0] fwd_sel,
  output logic               stall
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  logic [DEPTH:1]                r_v;
  logic [DEPTH:1][SB_DST_W-1:0]  r_dst;
  logic [DEPTH:1][SB_LAT_W-1:0]  r_lat;
  sb_entry_t [DEPTH:1]           w_sb;
  sb_entry_t                     w_new;
  logic [NSRC-1:0]               w_haz;
  logic                          w_stall;

  always_comb begin
    for (int k = 1; k <= DEPTH; k++) begin
      w_sb[k].v   = r_v[k];
      w_sb[k].dst = r_dst[k];
      w_sb[k].lat = r_lat[k];
    end
  end

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_pick
    fwd_pick #(
      .RW    (RW),
      .DEPTH (DEPTH),
      .SW    (SW)
    ) u_pick (
      .i_valid  (id_valid),
      .i_used   (id_src_used[gi]),
      .i_src    (id_src[gi*RW +: RW]),
      .i_sb     (w_sb),
      .o_sel    (fwd_sel[gi*SW +: SW]),
      .o_hazard (w_haz[gi])
    );
  end

  // A flushed instruction never stalls: the redirect supersedes it.
  assign w_stall = (|w_haz) && !flush;
  assign stall   = w_stall;

  always_comb begin
    w_new.v   = id_valid && id_wr && (id_dst != '0) && !w_stall && !flush;
    w_new.dst = SB_DST_W'(id_dst);
    w_new.lat = SB_LAT_W'(id_lat);
  end

  // Issue -> stage 1 -> ... -> stage DEPTH; shifts even while stalling so
  // older producers keep advancing toward readiness.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v <= '0;
    end else begin
      r_v[1] <= w_new.v;
      for (int k = 2; k <= DEPTH; k++) begin
        r_v[k] <= r_v[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_dst[1] <= w_new.dst;
    r_lat[1] <= w_new.lat;
    for (int k = 2; k <= DEPTH; k++) begin
      r_dst[k] <= r_dst[k-1];
      r_lat[k] <= r_lat[k-1];
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_fwd_scoreboard
// Directed vector table for the named pipeline scenarios, followed by a
// randomized run compared against a reference model that keeps a list of
// accepted writers with their issue cycle and derives stage = age.
// ---------------------------------------------------------------------------
module tb_fwd_scoreboard;

  localparam int RW    = 5;
  localparam int DEPTH = 3;
  localparam int NSRC  = 2;
  localparam int SW    = $clog2(DEPTH + 1);
  localparam int LW    = $clog2(DEPTH);

  logic               clk = 1'b0;
  logic               reset;
  logic               id_valid;
  logic [NSRC*RW-1:0] id_src;
  logic [NSRC-1:0]    id_src_used;
  logic               id_wr;
  logic [RW-1:0]      id_dst;
  logic [LW-1:0]      id_lat;
  logic               flush;
  logic [NSRC*SW-1:0] fwd_sel;
  logic               stall;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]        stall_cnt;
`endif

  always #5 clk = ~clk;

  fwd_scoreboard #(
    .RW(RW), .DEPTH(DEPTH), .NSRC(NSRC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .id_wr       (id_wr),
    .id_dst      (id_dst),
    .id_lat      (id_lat),
    .flush       (flush),
    .fwd_sel     (fwd_sel),
    .stall       (stall)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit vld, input bit wr, input bit fl,
                       input bit [1:0] used, input int s0, input int s1,
                       input int dst, input int lat);
    reset       = rst;
    id_valid    = vld;
    id_wr       = wr;
    flush       = fl;
    id_src_used = used;
    id_src      = {RW'(s1), RW'(s0)};
    id_dst      = RW'(dst);
    id_lat      = LW'(lat);
  endtask

  typedef struct {
    bit       rst, vld, wr, fl;
    bit [1:0] used;
    int       s0, s1, dst, lat;
    bit       chk;
    int       e_stall;
    bit       chk_sel;
    int       e_sel0, e_sel1;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t row(bit rst, bit vld, bit wr, bit fl, bit [1:0] used,
                               int s0, int s1, int dst, int lat,
                               bit chk, int st, bit cs, int e0, int e1);
    vec_t v;
    v.rst = rst; v.vld = vld; v.wr = wr; v.fl = fl; v.used = used;
    v.s0 = s0; v.s1 = s1; v.dst = dst; v.lat = lat;
    v.chk = chk; v.e_stall = st; v.chk_sel = cs; v.e_sel0 = e0; v.e_sel1 = e1;
    return v;
  endfunction

  function automatic vec_t idle();
    return row(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 0);
  endfunction

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) vt.push_back(idle());
  endtask

  // Reference model: accepted writers with the cycle they issued.
  typedef struct { int t; int dst; int lat; } wr_t;
  wr_t    mq[$];
  int     now;
  longint mcnt;

  task automatic model_pick(input bit vld, input bit used, input int src,
                            output int sel, output bit haz);
    int best;
    best = DEPTH + 1;
    sel  = 0;
    haz  = 1'b0;
    if (vld && used && src != 0) begin
      foreach (mq[j]) begin
        int age;
        age = now - mq[j].t;
        if (age >= 1 && age <= DEPTH && mq[j].dst == src && age < best) best = age;
      end
      if (best <= DEPTH) begin
        foreach (mq[j]) begin
          if (now - mq[j].t == best) begin
            if (best > mq[j].lat) sel = best;
            else haz = 1'b1;
          end
        end
      end
    end
  endtask

  initial begin
    int cnt_exp;
    drive(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);

    // Reset, then idle.
    vt.push_back(row(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(row(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    add_idle(1);
    // Back-to-back ALU on $3.
    vt.push_back(row(0, 1, 1, 0, 2'b11, 1, 2, 3, 0, 1, 0, 1, 0, 0));
    vt.push_back(row(0, 1, 1, 0, 2'b11, 3, 3, 4, 0, 1, 0, 1, 1, 1));
    vt.push_back(row(0, 1, 0, 0, 2'b01, 3, 0, 0, 0, 1, 0, 1, 2, 0));
    add_idle(3);
    // Load-use on $5: one stall, then forward from MEM.
    vt.push_back(row(0, 1, 1, 0, 2'b01, 1, 0, 5, 1, 1, 0, 1, 0, 0));
    vt.push_back(row(0, 1, 1, 0, 2'b11, 5, 0, 6, 0, 1, 1, 0, 0, 0));
    vt.push_back(row(0, 1, 1, 0, 2'b11, 5, 0, 6, 0, 1, 0, 1, 2, 0));
    add_idle(3);
    // Youngest of two $7 writers wins.
    vt.push_back(row(0, 1, 1, 0, 2'b00, 0, 0, 7, 0, 1, 0, 1, 0, 0));
    vt.push_back(row(0, 1, 1, 0, 2'b00, 0, 0, 7, 0, 1, 0, 1, 0, 0));
    vt.push_back(row(0, 1, 0, 0, 2'b11, 7, 7, 0, 0, 1, 0, 1, 1, 1));
    add_idle(3);
    // lat = 2: two stalls, then forward from WB.
    vt.push_back(row(0, 1, 1, 0, 2'b00, 0, 0, 9, 2, 1, 0, 1, 0, 0));
    vt.push_back(row(0, 1, 0, 0, 2'b01, 9, 0, 0, 0, 1, 1, 0, 0, 0));
    vt.push_back(row(0, 1, 0, 0, 2'b01, 9, 0, 0, 0, 1, 1, 0, 0, 0));
    vt.push_back(row(0, 1, 0, 0, 2'b01, 9, 0, 0, 0, 1, 0, 1, 3, 0));
    add_idle(3);
    // $0 writer is never recorded; unused operand on a live load never matches.
    vt.push_back(row(0, 1, 1, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    vt.push_back(row(0, 1, 1, 0, 2'b00, 0, 0, 8, 1, 1, 0, 1, 0, 0));
    vt.push_back(row(0, 1, 0, 0, 2'b01, 0, 8, 0, 0, 1, 0, 1, 0, 0));
    vt.push_back(row(0, 1, 0, 0, 2'b11, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    add_idle(3);
    // Flush beats stall; flushed writer of $6 leaves nothing behind.
    vt.push_back(row(0, 1, 1, 0, 2'b01, 1, 0, 5, 1, 1, 0, 1, 0, 0));
    vt.push_back(row(0, 1, 1, 1, 2'b01, 5, 0, 6, 0, 1, 0, 0, 0, 0));
    vt.push_back(row(0, 1, 0, 0, 2'b01, 6, 0, 0, 0, 1, 0, 1, 0, 0));
    add_idle(3);
    // Reset during a load-use stall clears it next cycle.
    vt.push_back(row(0, 1, 1, 0, 2'b01, 1, 0, 5, 1, 1, 0, 1, 0, 0));
    vt.push_back(row(1, 1, 1, 0, 2'b01, 5, 0, 6, 0, 1, 1, 0, 0, 0));
    vt.push_back(row(0, 1, 1, 0, 2'b01, 5, 0, 6, 0, 1, 0, 1, 0, 0));
    add_idle(3);

    cnt_exp = 0;
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i].rst, vt[i].vld, vt[i].wr, vt[i].fl, vt[i].used,
            vt[i].s0, vt[i].s1, vt[i].dst, vt[i].lat);
      #2;
      if (vt[i].chk) begin
        check($sformatf("vec%0d stall", i), int'(stall), vt[i].e_stall);
        if (vt[i].chk_sel) begin
          check($sformatf("vec%0d sel0", i), int'(fwd_sel[SW-1:0]), vt[i].e_sel0);
          check($sformatf("vec%0d sel1", i), int'(fwd_sel[2*SW-1:SW]), vt[i].e_sel1);
        end
`ifdef FWD_STALL_CNT_EN
        check($sformatf("vec%0d stall_cnt", i), int'(stall_cnt), cnt_exp);
`endif
      end
      if (vt[i].rst) cnt_exp = 0;
      else if (vt[i].e_stall != 0) cnt_exp++;
    end

    // Randomized run against the reference model.
    @(negedge clk);
    drive(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    mq.delete();
    now  = 0;
    mcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      bit       rst, vld, wr, fl, h0, h1, est;
      bit [1:0] used;
      int       s0, s1, dst, lat, e0, e1;
      @(negedge clk);
      rst  = ($urandom_range(0, 63) == 0);
      vld  = ($urandom_range(0, 3) != 0);
      wr   = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 7) == 0);
      used = 2'($urandom_range(0, 3));
      s0   = $urandom_range(0, 7);
      s1   = $urandom_range(0, 7);
      dst  = $urandom_range(0, 7);
      lat  = $urandom_range(0, 3);
      drive(rst, vld, wr, fl, used, s0, s1, dst, lat);
      #2;
      model_pick(vld, used[0], s0, e0, h0);
      model_pick(vld, used[1], s1, e1, h1);
      est = (h0 || h1) && !fl;
      check($sformatf("rnd%0d stall", c), int'(stall), int'(est));
      if (!est && !fl) begin
        check($sformatf("rnd%0d sel0", c), int'(fwd_sel[SW-1:0]), e0);
        check($sformatf("rnd%0d sel1", c), int'(fwd_sel[2*SW-1:SW]), e1);
      end
`ifdef FWD_STALL_CNT_EN
      check($sformatf("rnd%0d stall_cnt", c), int'(stall_cnt), int'(mcnt));
`endif
      if (rst) begin
        mq.delete();
        mcnt = 0;
      end else begin
        if (est && mcnt != 64'hFFFF_FFFF) mcnt++;
        if (vld && wr && dst != 0 && !est && !fl) mq.push_back('{t: now, dst: dst, lat: lat});
      end
      now++;
      while (mq.size() > 0 && (now - mq[0].t) > DEPTH) void'(mq.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
